score_tracker: RTL and testbench
================================

SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 Parameter MAX_SCORE, default 1999, SHALL set the saturation ceiling of score, legal range 1..2047.
REQ-002 Parameter HOLDOFF, default 50_000_000, SHALL set the clk cycles after entering OVER during which start is ignored, legal range >= 1.
REQ-003 clk  input  1  SHALL be the single system clock; all state changes occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be the level from the start/flap button, already debounced and synchronous to clk.
REQ-006 pipe_pass  input  1  SHALL be the level asserted while the bird is inside a pipe gap, synchronous to clk.
REQ-007 collision  input  1  SHALL be the level asserted while the bird overlaps a pipe or the ground, synchronous to clk.
REQ-008 game_state  output  1  SHALL be 0 only in OVER and 1 otherwise; it feeds the segment display stage directly.
REQ-009 score  output  11  SHALL be the current-run score, unsigned binary.
REQ-010 high_score  output  11  SHALL be the best score since reset, unsigned binary.
REQ-011 new_record  output  1  SHALL be high while in OVER if the run ended with score strictly greater than the previous high_score.

Function
REQ-012 FSM SHALL have states IDLE, PLAY and OVER, each registered.
REQ-013 start, pipe_pass and collision SHALL each pass through a one-register rising-edge detector; only a 0->1 transition produces an event, one cycle after the input edge.
REQ-014 IDLE -> PLAY on a start event; score SHALL clear to 0 on that transition edge.
REQ-015 PLAY -> OVER on a collision event; all other events in IDLE/OVER except those listed SHALL be ignored.
REQ-016 In PLAY, each pipe_pass event SHALL increment score by 1 on the same edge as the event.
REQ-017 Score SHALL saturate: an increment when score == MAX_SCORE leaves it at MAX_SCORE.
REQ-018 Simultaneous pipe_pass and collision events in PLAY SHALL count the pass first: score increments and the state moves to OVER on the same edge, and the incremented value is used for the high-score compare.
REQ-019 On entering OVER, if final score > high_score, high_score SHALL update to the final score on the next edge and new_record SHALL assert; equal scores do not set new_record.
REQ-020 On entering OVER, a holdoff counter SHALL load HOLDOFF-1 and decrement each cycle to 0; start events while it is nonzero SHALL be discarded.
REQ-021 OVER -> PLAY on a start event once the holdoff counter is 0; score clears to 0 and new_record deasserts on that edge; high_score is retained.
REQ-022 score SHALL remain frozen at its final value throughout OVER for display.
REQ-023 A start level held high across the holdoff expiry SHALL NOT restart the game; a fresh rising edge is required.
REQ-024 Output latency: score, game_state and new_record SHALL be registered outputs, updating on the edge that processes the event, with no combinational input-to-output path.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, score 0, high_score 0, new_record 0, game_state 1, holdoff counter 0 and all edge-detect registers 0.
REQ-026 Reset asserted mid-PLAY or mid-OVER SHALL abandon the run without updating high_score.
REQ-027 After rst_n deasserts, an input already high SHALL NOT produce an event until it goes low and high again.

Verification
REQ-028 Reset, start pulse, 5 pipe_pass pulses, collision pulse -> score 5, game_state 0, high_score 5, new_record 1.
REQ-029 With MAX_SCORE=3: start then 6 pipe_pass pulses -> score sequence 1,2,3,3,3,3, with no wrap to 0.
REQ-030 pipe_pass and collision rising on the same cycle with score 4 and high_score 4 -> score 5, state OVER, high_score 5, new_record 1.
REQ-031 HOLDOFF=10, in OVER: start pulses at cycles 3 and 12 after entry -> first is ignored, second enters PLAY with score 0 and high_score unchanged.
REQ-032 Second run ends with score 2 against high_score 5 -> high_score 5, new_record 0; an equal score of 5 also leaves new_record 0.
REQ-033 rst_n pulsed low mid-PLAY with score 7 -> immediate IDLE, score 0, high_score 0; a start held high through reset produces no event until re-pressed.

Source files
------------

// File: rtl/score_tracker.sv
// Score/high-score tracker with IDLE/PLAY/OVER game FSM and post-game start holdoff.
// Latency: input level -> event on the next edge; all outputs registered. No backpressure: events are level edges, never stalled.
module score_tracker #(
    parameter int MAX_SCORE = 1999,
    parameter int HOLDOFF   = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pipe_pass,
    input  logic        collision,
    output logic        game_state,
    output logic [10:0] score,
    output logic [10:0] high_score,
    output logic        new_record
);

    localparam int             HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0]  HOLD_LOAD = HW'(HOLDOFF - 1);
    localparam logic [HW-1:0]  HOLD_ONE  = HW'(1);
    localparam logic [10:0]    SCORE_MAX = 11'(MAX_SCORE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [10:0]   score_q, score_d;
    logic [10:0]   high_q, high_d;
    logic          new_record_q, new_record_d;
    logic          game_state_q, game_state_d;
    logic [HW-1:0] hold_q, hold_d;

    // Each detector remembers "input was low last cycle"; resetting it to 0
    // means a level already high at reset release never counts as an edge.
    logic          start_low_q, pass_low_q, coll_low_q;
    logic          start_evt, pass_evt, coll_evt;
    logic [10:0]   score_inc;

    assign start_evt = start & start_low_q;
    assign pass_evt  = pipe_pass & pass_low_q;
    assign coll_evt  = collision & coll_low_q;
    assign score_inc = (score_q == SCORE_MAX) ? score_q : score_q + 11'd1;

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        high_d       = high_q;
        new_record_d = new_record_q;
        hold_d       = (hold_q != '0) ? hold_q - HOLD_ONE : hold_q;

        case (state_q)
            IDLE: begin
                if (start_evt) begin
                    state_d = PLAY;
                    score_d = '0;
                end
            end
            PLAY: begin
                if (pass_evt)
                    score_d = score_inc;
                // A pass on the collision edge counts toward the final score.
                if (coll_evt) begin
                    state_d      = OVER;
                    hold_d       = HOLD_LOAD;
                    new_record_d = ((pass_evt ? score_inc : score_q) > high_q);
                end
            end
            OVER: begin
                if (score_q > high_q)
                    high_d = score_q;
                if (start_evt && (hold_q == '0)) begin
                    state_d      = PLAY;
                    score_d      = '0;
                    new_record_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        game_state_d = (state_d != OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            score_q      <= '0;
            high_q       <= '0;
            new_record_q <= 1'b0;
            game_state_q <= 1'b1;
            hold_q       <= '0;
            start_low_q  <= 1'b0;
            pass_low_q   <= 1'b0;
            coll_low_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            high_q       <= high_d;
            new_record_q <= new_record_d;
            game_state_q <= game_state_d;
            hold_q       <= hold_d;
            start_low_q  <= ~start;
            pass_low_q   <= ~pipe_pass;
            coll_low_q   <= ~collision;
        end
    end

    assign game_state = game_state_q;
    assign score      = score_q;
    assign high_score = high_q;
    assign new_record = new_record_q;

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: main instance (HOLDOFF=10) plus a MAX_SCORE=3 instance sharing stimulus.
module tb_score_tracker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        pipe_pass;
    logic        collision;
    logic        game_state, new_record;
    logic [10:0] score, high_score;
    logic        sat_game_state, sat_new_record;
    logic [10:0] sat_score, sat_high_score;

    int checks = 0;
    int errors = 0;

    score_tracker #(.MAX_SCORE(1999), .HOLDOFF(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pipe_pass  (pipe_pass),
        .collision  (collision),
        .game_state (game_state),
        .score      (score),
        .high_score (high_score),
        .new_record (new_record)
    );

    score_tracker #(.MAX_SCORE(3), .HOLDOFF(10)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pipe_pass  (pipe_pass),
        .collision  (collision),
        .game_state (sat_game_state),
        .score      (sat_score),
        .high_score (sat_high_score),
        .new_record (sat_new_record)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1; tick(); start = 1'b0; tick();
    endtask

    task automatic pulse_pass;
        pipe_pass = 1'b1; tick(); pipe_pass = 1'b0; tick();
    endtask

    task automatic pulse_coll;
        collision = 1'b1; tick(); collision = 1'b0; tick();
    endtask

    // Called right after a collision pulse; the start event lands 12 edges after OVER entry.
    task automatic restart;
        repeat (10) tick();
        pulse_start();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; pipe_pass = 1'b0; collision = 1'b0;
        repeat (3) tick();
        checks++; if (game_state !== 1'b1) begin errors++; $display("FAIL reset_game_state got %0d want 1", game_state); end
        checks++; if (score !== 11'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
        checks++; if (high_score !== 11'd0) begin errors++; $display("FAIL reset_high got %0d want 0", high_score); end
        checks++; if (new_record !== 1'b0) begin errors++; $display("FAIL reset_new_record got %0d want 0", new_record); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_run;
        pulse_start();
        checks++; if (game_state !== 1'b1) begin errors++; $display("FAIL play_game_state got %0d want 1", game_state); end
        for (int i = 1; i <= 5; i++) begin
            pulse_pass();
            checks++; if (score !== 11'(i)) begin errors++; $display("FAIL pass_count got %0d want %0d", score, i); end
        end
        collision = 1'b1; tick();
        checks++; if (game_state !== 1'b0) begin errors++; $display("FAIL over_entry_state got %0d want 0", game_state); end
        checks++; if (new_record !== 1'b1) begin errors++; $display("FAIL over_entry_record got %0d want 1", new_record); end
        collision = 1'b0; tick();
        checks++; if (score !== 11'd5) begin errors++; $display("FAIL run1_score got %0d want 5", score); end
        checks++; if (high_score !== 11'd5) begin errors++; $display("FAIL run1_high got %0d want 5", high_score); end
    endtask

    // Entered OVER two edges ago (E0 = collision edge, now after E1).
    task automatic test_holdoff;
        tick();
        start = 1'b1; pipe_pass = 1'b1; tick();
        checks++; if (game_state !== 1'b0) begin errors++; $display("FAIL holdoff_early_start got %0d want 0", game_state); end
        checks++; if (score !== 11'd5) begin errors++; $display("FAIL over_frozen_score got %0d want 5", score); end
        start = 1'b0; pipe_pass = 1'b0; tick();
        repeat (7) tick();
        start = 1'b1; tick();
        checks++; if (game_state !== 1'b1) begin errors++; $display("FAIL holdoff_late_start got %0d want 1", game_state); end
        checks++; if (score !== 11'd0) begin errors++; $display("FAIL restart_score got %0d want 0", score); end
        checks++; if (new_record !== 1'b0) begin errors++; $display("FAIL restart_record got %0d want 0", new_record); end
        checks++; if (high_score !== 11'd5) begin errors++; $display("FAIL restart_high got %0d want 5", high_score); end
        start = 1'b0; tick();
    endtask

    task automatic test_second_run;
        pulse_pass(); pulse_pass(); pulse_coll();
        checks++; if (score !== 11'd2) begin errors++; $display("FAIL run2_score got %0d want 2", score); end
        checks++; if (high_score !== 11'd5) begin errors++; $display("FAIL run2_high got %0d want 5", high_score); end
        checks++; if (new_record !== 1'b0) begin errors++; $display("FAIL run2_record got %0d want 0", new_record); end
        // Start pressed inside holdoff and held past expiry must not restart.
        start = 1'b1;
        repeat (14) tick();
        checks++; if (game_state !== 1'b0) begin errors++; $display("FAIL held_start got %0d want 0", game_state); end
        start = 1'b0; tick();
        pulse_start();
        checks++; if (game_state !== 1'b1) begin errors++; $display("FAIL repress_start got %0d want 1", game_state); end
        for (int i = 0; i < 5; i++) pulse_pass();
        pulse_coll();
        checks++; if (score !== 11'd5) begin errors++; $display("FAIL run3_score got %0d want 5", score); end
        checks++; if (high_score !== 11'd5) begin errors++; $display("FAIL run3_high got %0d want 5", high_score); end
        checks++; if (new_record !== 1'b0) begin errors++; $display("FAIL equal_record got %0d want 0", new_record); end
    endtask

    task automatic test_simultaneous;
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        pulse_start();
        for (int i = 0; i < 4; i++) pulse_pass();
        pulse_coll();
        checks++; if (high_score !== 11'd4) begin errors++; $display("FAIL sim_setup_high got %0d want 4", high_score); end
        restart();
        for (int i = 0; i < 4; i++) pulse_pass();
        pipe_pass = 1'b1; collision = 1'b1; tick();
        checks++; if (score !== 11'd5) begin errors++; $display("FAIL sim_score got %0d want 5", score); end
        checks++; if (game_state !== 1'b0) begin errors++; $display("FAIL sim_state got %0d want 0", game_state); end
        checks++; if (new_record !== 1'b1) begin errors++; $display("FAIL sim_record got %0d want 1", new_record); end
        pipe_pass = 1'b0; collision = 1'b0; tick();
        checks++; if (high_score !== 11'd5) begin errors++; $display("FAIL sim_high got %0d want 5", high_score); end
    endtask

    task automatic test_saturation;
        logic [10:0] exp_seq [6];
        exp_seq = '{11'd1, 11'd2, 11'd3, 11'd3, 11'd3, 11'd3};
        restart();
        checks++; if (sat_score !== 11'd0) begin errors++; $display("FAIL sat_start got %0d want 0", sat_score); end
        for (int i = 0; i < 6; i++) begin
            pulse_pass();
            checks++; if (sat_score !== exp_seq[i]) begin errors++; $display("FAIL sat_seq%0d got %0d want %0d", i, sat_score, exp_seq[i]); end
        end
        checks++; if (score !== 11'd6) begin errors++; $display("FAIL unsat_score got %0d want 6", score); end
    endtask

    task automatic test_reset_mid_play;
        pulse_pass();
        checks++; if (score !== 11'd7) begin errors++; $display("FAIL pre_rst_score got %0d want 7", score); end
        checks++; if (high_score !== 11'd5) begin errors++; $display("FAIL pre_rst_high got %0d want 5", high_score); end
        start = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (score !== 11'd0) begin errors++; $display("FAIL async_rst_score got %0d want 0", score); end
        checks++; if (high_score !== 11'd0) begin errors++; $display("FAIL async_rst_high got %0d want 0", high_score); end
        checks++; if (game_state !== 1'b1) begin errors++; $display("FAIL async_rst_state got %0d want 1", game_state); end
        tick(); rst_n = 1'b1;
        repeat (3) tick();
        // Still IDLE if the held start gave no event: a pass must not score.
        pulse_pass();
        checks++; if (score !== 11'd0) begin errors++; $display("FAIL held_through_rst got %0d want 0", score); end
        start = 1'b0; tick();
        pulse_start(); pulse_pass();
        checks++; if (score !== 11'd1) begin errors++; $display("FAIL repress_after_rst got %0d want 1", score); end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_holdoff();
        test_second_run();
        test_simultaneous();
        test_saturation();
        test_reset_mid_play();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
